// File: rtl/sd_spi_master.sv
// SPI mode-0 byte initiator for the SD card path: MSB-first shift out on mosi while sampling miso.
// Optional macro SD_SPI_SLOW_INIT_EN lets `slow` pick SLOW_DIV as the SCK half-period for card init.
module sd_spi_master #(
  parameter int DIV      = 2,
  parameter int SLOW_DIV = 64
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       cs_en,
  input  logic       slow,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       ss
);

  localparam int HMAX = (SLOW_DIV > DIV) ? SLOW_DIV : DIV;
  localparam int CW   = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    edge_cnt;
  logic [7:0]    sreg;
  // Half-period minus one, so the widest half-period still fits in CW bits.
  logic [CW-1:0] hm1;

`ifdef SD_SPI_SLOW_INIT_EN
  localparam logic [CW-1:0] SLOW_M1 = CW'(SLOW_DIV - 1);
`else
  logic unused_slow;
  assign unused_slow = slow;
  assign hm1 = DIV_M1;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      edge_cnt <= '0;
      sreg     <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b1;
      ss       <= 1'b1;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
`ifdef SD_SPI_SLOW_INIT_EN
      hm1      <= DIV_M1;
`endif
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          ss       <= ~cs_en;
          sck      <= 1'b0;
          mosi     <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          if (tx_valid && tx_ready) begin
            sreg     <= tx_data;
            cnt      <= '0;
            edge_cnt <= '0;
            mosi     <= tx_data[7];
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            state    <= SHIFT;
`ifdef SD_SPI_SLOW_INIT_EN
            hm1      <= slow ? SLOW_M1 : DIV_M1;
`endif
          end
        end
        SHIFT: begin
          // Even edge index is a rising SCK edge (sample), odd is falling (present next bit).
          if (cnt == hm1) begin
            cnt      <= '0;
            edge_cnt <= edge_cnt + 4'd1;
            if (edge_cnt == 4'd15) begin
              sck      <= 1'b0;
              mosi     <= 1'b1;
              rx_data  <= sreg;
              rx_valid <= 1'b1;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              sck <= ~sck;
              if (!edge_cnt[0]) begin
                sreg <= {sreg[6:0], miso};
              end else begin
                mosi <= sreg[7];
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed self-checking bench for sd_spi_master; expected values are hand-computed from the timing rules.
module tb_sd_spi_master;

  logic       clk_sys = 1'b0;
  logic       reset, cs_en, slow, tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, rx_valid, busy, sck, mosi, ss, miso;
  logic [7:0] rx_data;
  logic       loop_en, miso_fix;

  int total = 0;
  int bad   = 0;

`ifdef SD_SPI_SLOW_INIT_EN
  localparam int SLOW_H = 64;
`else
  localparam int SLOW_H = 2;
`endif

  // Per-transfer observations filled in by applyStimulus
  logic [7:0] r_got, r_mosi;
  int         r_lat, r_rises, r_first, r_period;
  logic       r_ss_first, r_mosi_first, r_sck_first, r_ss_rx, r_idle_ok;
  int         drop_at = 0;
  int         rx_seen;

  assign miso = loop_en ? mosi : miso_fix;

  always #5 clk_sys = ~clk_sys;

  sd_spi_master #(.DIV(2), .SLOW_DIV(64)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .cs_en    (cs_en),
    .slow     (slow),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .ss       (ss)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Offer one byte, then watch cycle by cycle (k=1 is the cycle after accept) until rx_valid.
  task automatic applyStimulus(input logic [7:0] data, input logic chain,
                               input logic [7:0] next_data, input int h);
    logic prev;
    tx_data = data;
    tx_valid = 1'b1;
    r_lat = -1; r_rises = 0; r_first = -1; r_period = -1;
    r_mosi = '0; r_got = '0; r_idle_ok = 1'b0; r_ss_rx = 1'b1;
    @(posedge clk_sys);
    if (!chain) begin
      #1 tx_valid = 1'b0;
    end
    prev = 1'b0;
    for (int k = 1; k <= 16 * h + 8; k++) begin
      @(negedge clk_sys);
      if (k == 1) begin
        r_ss_first = ss; r_mosi_first = mosi; r_sck_first = sck;
      end
      if (k == drop_at) cs_en = 1'b0;
      if (sck && !prev) begin
        r_mosi = {r_mosi[6:0], mosi};
        r_rises++;
        if (r_rises == 1) r_first = k;
        else if (r_rises == 2) r_period = k - r_first;
      end
      prev = sck;
      if (rx_valid) begin
        r_lat = k;
        r_got = rx_data;
        r_ss_rx = ss;
        r_idle_ok = !sck && mosi && !busy && tx_ready;
        if (chain) tx_data = next_data;
        break;
      end
    end
  endtask

  task automatic check_xfer(input string tag, input logic [7:0] exp_rx,
                            input logic [7:0] exp_mosi, input int h);
    checkOutput({tag, "_lat"}, r_lat, 16 * h + 1);
    checkOutput({tag, "_rises"}, r_rises, 8);
    checkOutput({tag, "_rx"}, r_got, exp_rx);
    checkOutput({tag, "_mosi_bits"}, r_mosi, exp_mosi);
    checkOutput({tag, "_first_bit"}, {r_sck_first, r_mosi_first}, {1'b0, exp_mosi[7]});
    checkOutput({tag, "_idle_at_rx"}, r_idle_ok, 1);
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!tx_ready && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput("ready_wait", tx_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; cs_en = 1'b0; slow = 1'b0; tx_valid = 1'b0; tx_data = '0;
    loop_en = 1'b1; miso_fix = 1'b1;
    repeat (3) @(negedge clk_sys);
    checkOutput("reset_pins", {sck, mosi, ss, tx_ready, rx_valid, busy}, 6'b011000);
    checkOutput("reset_rx_data", rx_data, 0);
    reset = 1'b0;
    @(negedge clk_sys);
    checkOutput("ready_after_reset", tx_ready, 1);
    checkOutput("ss_idle_deselected", ss, 1);

    // Loopback 0xA5, cs_en rising together with tx_valid
    cs_en = 1'b1;
    applyStimulus(8'hA5, 1'b0, 8'h00, 2);
    checkOutput("a5_ss_with_bit7", r_ss_first, 0);
    checkOutput("a5_first_rise", r_first, 3);
    checkOutput("a5_sck_period", r_period, 4);
    check_xfer("a5", 8'hA5, 8'hA5, 2);

    // miso tied high, sending zeros
    wait_ready;
    loop_en = 1'b0;
    applyStimulus(8'h00, 1'b0, 8'h00, 2);
    check_xfer("zero", 8'hFF, 8'h00, 2);
    @(negedge clk_sys);
    checkOutput("zero_mosi_idle", {mosi, sck, rx_valid}, 3'b100);

    // Back-to-back bytes with tx_valid held
    loop_en = 1'b1;
    applyStimulus(8'h40, 1'b1, 8'h00, 2);
    check_xfer("b2b0", 8'h40, 8'h40, 2);
    applyStimulus(8'h00, 1'b1, 8'h95, 2);
    check_xfer("b2b1", 8'h00, 8'h00, 2);
    checkOutput("b2b1_period", r_period, 4);
    applyStimulus(8'h95, 1'b0, 8'h00, 2);
    check_xfer("b2b2", 8'h95, 8'h95, 2);

    // cs_en dropped mid-byte
    wait_ready;
    drop_at = 5;
    applyStimulus(8'h3C, 1'b0, 8'h00, 2);
    drop_at = 0;
    check_xfer("drop", 8'h3C, 8'h3C, 2);
    checkOutput("drop_ss_at_rx", r_ss_rx, 0);
    @(negedge clk_sys);
    checkOutput("drop_ss_after", ss, 1);
    checkOutput("drop_rx_pulse_one_cycle", rx_valid, 0);
    cs_en = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    checkOutput("cs_reassert", ss, 0);

    // slow half-period (only effective with the macro)
    wait_ready;
    slow = 1'b1;
    applyStimulus(8'h5A, 1'b0, 8'h00, SLOW_H);
    slow = 1'b0;
    checkOutput("slow_period", r_period, 2 * SLOW_H);
    check_xfer("slow", 8'h5A, 8'h5A, SLOW_H);

    // Reset in the middle of a byte
    wait_ready;
    tx_data = 8'hC3;
    tx_valid = 1'b1;
    @(posedge clk_sys);
    #1 tx_valid = 1'b0;
    repeat (4) @(negedge clk_sys);
    checkOutput("abort_busy_before", {busy, ss}, 2'b10);
    reset = 1'b1;
    @(negedge clk_sys);
    checkOutput("abort_pins", {sck, mosi, ss, rx_valid, busy, tx_ready}, 6'b011000);
    reset = 1'b0;
    @(negedge clk_sys);
    checkOutput("abort_ready_after", tx_ready, 1);
    rx_seen = 0;
    repeat (40) begin
      @(negedge clk_sys);
      if (rx_valid) rx_seen++;
    end
    checkOutput("abort_no_rx_valid", rx_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_spi_master.md
# sd_spi_master

SPI-mode-0 byte initiator that drives the SD card interface from the core side: it shifts bytes out on MOSI while sampling MISO, controls chip select, and generates SCK from `clk_sys`. It is the initiator counterpart of the emulated SD card responder. Its `sck`/`mosi`/`ss` outputs feed the existing SD mux (virtual card or physical `SD_*` pins), and its `miso` input comes from that mux. Upstream logic (sector loader/OSD firmware) issues bytes through a valid/ready handshake.

## Interface
Parameters:
- `DIV`, 2, SCK half-period in `clk_sys` cycles (≥1)
- `SLOW_DIV`, 64, SCK half-period while `slow`=1 (≥1; used only with `SD_SPI_SLOW_INIT_EN`)

Ports (one clock; reset is synchronous and active-high):
- `clk_sys` in 1: system clock
- `reset` in 1: synchronous, active-high
- `cs_en` in 1: 1 = assert card select
- `slow` in 1: select `SLOW_DIV` half-period
- `tx_valid` in 1: byte offered
- `tx_data` in 8: byte to send, MSB first
- `tx_ready` out 1: engine idle, will accept a byte
- `rx_valid` out 1: one-cycle pulse, `rx_data` valid
- `rx_data` out 8: byte received on MISO
- `busy` out 1: byte transfer in progress
- `sck` out 1: SPI clock, idle low
- `mosi` out 1: SPI data out, idle high
- `miso` in 1: SPI data in
- `ss` out 1: active-low chip select

## Operation
- States: IDLE, SHIFT.
- IDLE:
  - `tx_ready`=1, `sck`=0, `mosi`=1.
  - `ss` <= ~`cs_en` every cycle.
  - On `tx_valid & tx_ready`: latch `tx_data` into the shift register, latch the half-period (H), clear the half-period and edge counters, drive `mosi`=bit7, set `busy`, go to SHIFT.
- SHIFT:
  - A counter runs 0..H-1; each wrap toggles `sck`. The edge count runs 0..15.
  - On a rising edge (even edge index): sample `miso` into the shift-register LSB side.
  - On a falling edge (odd index, except the last): present the next MSB on `mosi`.
  - After edge 15 (the 8th falling edge): `sck`=0, `mosi`=1, `rx_data` <= assembled byte, `rx_valid`=1 for one cycle, go to IDLE.
- `cs_en` and `slow` are ignored during SHIFT. `ss` never changes mid-byte; a change is applied on the first IDLE cycle.
- Bit order is MSB first both directions; `rx_data`[7] is the first sampled bit.

## Timing
- Reset values: `sck`=0, `mosi`=1, `ss`=1, `tx_ready`=0 while `reset`=1, `rx_valid`=0, `rx_data`=0, `busy`=0.
- `tx_ready`=1 on the first cycle after `reset` deasserts.
- Accept at edge N. From N+1:
  - `mosi`=bit7, `sck`=0.
  - `sck` rises at N+1+H, N+1+3H, …, N+1+15H; `miso` is sampled on those edges.
  - The final falling edge is at N+1+16H.
  - `rx_valid`, `tx_ready`=1 and `busy`=0 all occur in that same cycle.
- Byte period is 16H cycles plus 1 accept cycle. Back-to-back: `tx_valid` held high is accepted in the `rx_valid` cycle, giving a 1-cycle gap between bytes.
- `tx_valid` without `tx_ready` is ignored. Data is not required to stay stable after acceptance.
- Reset mid-byte aborts immediately: no `rx_valid`, outputs return to reset values next cycle.
- `cs_en` toggling in IDLE: `ss` follows with 1-cycle latency. When `cs_en` and `tx_valid` rise in the same cycle, `ss` goes low in the same cycle that bit7 appears.

## Configuration
- `SD_SPI_SLOW_INIT_EN` defined: `slow` selects H=`SLOW_DIV` (card init ≤400 kHz); H is latched at byte accept.
- `SD_SPI_SLOW_INIT_EN` undefined: `slow` is ignored, H=`DIV` always, and no `SLOW_DIV` logic is built.

## Test plan
- Reset, `DIV`=2, `cs_en`=1, send 0xA5 with `miso` looped from `mosi` -> `ss`=0; 8 `sck` pulses of 4-cycle period; `rx_valid` at accept+33; `rx_data`=0xA5.
- `miso` tied 1, send 0x00 -> `mosi` low during bits 7..0, then idles high; `rx_data`=0xFF.
- Three bytes 0x40,0x00,0x95 with `tx_valid` held -> each accepted in the previous `rx_valid` cycle; SCK period 4 cycles with a 1-cycle gap between bytes; no lost bytes.
- `cs_en` dropped mid-byte -> `ss` stays 0 until the cycle after `rx_valid`, then 1.
- With `SD_SPI_SLOW_INIT_EN`, `slow`=1, `SLOW_DIV`=64 -> `sck` period 128 cycles, `rx_valid` at accept+1025; same test without the macro -> period 4.
- `reset` asserted at the 5th rising edge -> no `rx_valid`; next cycle `sck`=0, `mosi`=1, `ss`=1; `tx_ready`=1 one cycle after release.
